// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: frame layout, FSM states and command codes for the SPI command link
package spi_seq_pkg;
  localparam int LEN_SPI = 32;
  localparam int SPI_CODE_LEN = 6;
  localparam int SPI_ADDR_LEN = 10;
  localparam int SPI_DATA_LEN = 16;
  localparam int SPI_DATA_OFS = 0;
  localparam int SPI_ADDR_OFS = SPI_DATA_OFS + SPI_DATA_LEN;
  localparam int SPI_CODE_OFS = SPI_ADDR_OFS + SPI_ADDR_LEN;
  localparam logic [SPI_CODE_LEN-1:0] CMD_DUMMY = 6'd0;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST_OFF = 6'd8;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_REC = 6'd4;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ADC = 6'd19;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ELEC = 6'd11;
  typedef enum logic [2:0] {IDLE, PRE, SETUP, LOW, HIGH, TAIL, POST} state_e;
  function automatic logic [LEN_SPI-1:0] pack_frame(
    input logic [SPI_CODE_LEN-1:0] code,
    input logic [SPI_ADDR_LEN-1:0] addr,
    input logic [SPI_DATA_LEN-1:0] data
  );
    return {code, addr, data};
  endfunction
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: first-word-fall-through command FIFO with occupancy level
module spi_cmd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic push_ok, pop_ok;
  // DEPTH is a power of two, so the level MSB alone marks full
  assign full = level_q[AW];
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_d = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = (push_ok && !pop_ok) ? level_q + (AW+1)'(1) :
              (!push_ok && pop_ok) ? level_q - (AW+1)'(1) : level_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues 32-bit command frames and shifts them out LSB-first over SPI,
// capturing miso into a response word and optionally appending an all-zero dummy frame
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int SCK_HALF = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_50M,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [LEN_SPI-1:0]            cmd_data,
  input  logic                          cmd_dummy,
  output logic                          rsp_valid,
  output logic [LEN_SPI-1:0]            rsp_data,
  output logic                          rsp_is_dummy,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sck,
  output logic                          mosi,
  output logic                          cs_n,
  input  logic                          miso
);
  localparam int BW = $clog2(LEN_SPI);
  localparam logic [7:0] H_LAST = 8'(SCK_HALF - 1);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [LEN_SPI-1:0] shift_q, shift_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic dummy_q, dummy_d, is_dummy_q, is_dummy_d;
  logic rsp_valid_q, rsp_valid_d, rsp_is_dummy_q, rsp_is_dummy_d;
  logic [1:0] miso_s_q, miso_s_d;
  logic [LEN_SPI:0] fifo_dout;
  logic fifo_pop, fifo_full, fifo_empty, last;
  spi_cmd_fifo #(.WIDTH(LEN_SPI + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_50M),
    .rst_n(rst_n),
    .push(cmd_valid && cmd_ready),
    .pop(fifo_pop),
    .din({cmd_dummy, cmd_data}),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );
  assign last = cnt_q == H_LAST;
  assign cmd_ready = rst_n && !fifo_full;
  assign sck = state_q != LOW;
  assign cs_n = !(state_q inside {SETUP, LOW, HIGH, TAIL});
  assign mosi = (state_q inside {SETUP, LOW, HIGH}) && shift_q[0];
  assign busy = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_is_dummy = rsp_is_dummy_q;
  always_comb begin
    state_d = state_q;
    cnt_d = last ? '0 : cnt_q + 8'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    cap_d = cap_q;
    dummy_d = dummy_q;
    is_dummy_d = is_dummy_q;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_is_dummy_d = rsp_is_dummy_q;
    miso_s_d = {miso_s_q[0], miso};
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_d = PRE;
          bit_d = '0;
          shift_d = fifo_dout[LEN_SPI-1:0];
          dummy_d = fifo_dout[LEN_SPI];
          is_dummy_d = 1'b0;
        end
      end
      PRE: if (last) state_d = SETUP;
      SETUP: if (last) state_d = LOW;
      LOW: if (last) begin
        cap_d[bit_q] = miso_s_q[1];
        state_d = &bit_q ? TAIL : HIGH;
        shift_d = shift_q >> 1;
        bit_d = bit_q + BW'(1);
      end
      HIGH: if (last) state_d = LOW;
      TAIL: if (last) begin
        state_d = POST;
        rsp_valid_d = 1'b1;
        rsp_data_d = cap_q;
        rsp_is_dummy_d = is_dummy_q;
      end
      // POST already gives the cs_n-high gap, so a dummy frame skips PRE
      POST: if (last) begin
        state_d = dummy_q ? SETUP : IDLE;
        shift_d = '0;
        is_dummy_d = dummy_q;
        dummy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50M) begin
    miso_s_q <= miso_s_d;
    shift_q <= shift_d;
    cap_q <= cap_d;
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      dummy_q <= 1'b0;
      is_dummy_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_is_dummy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      dummy_q <= dummy_d;
      is_dummy_q <= is_dummy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_is_dummy_q <= rsp_is_dummy_d;
    end
  end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: scoreboard bench with an SPI slave model on the H=5 instance
// and a mosi->miso loopback on a second H=3 instance
module tb_spi_cmd_sequencer;
  import spi_seq_pkg::*;
  logic clk = 0, rst_n = 0, enable = 0, cmd_valid = 0, cmd_dummy = 0, miso = 0;
  logic [31:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_is_dummy, busy, sck, mosi, cs_n;
  logic [31:0] rsp_data;
  logic [3:0] fifo_level;
  logic enable3 = 0, cmd_valid3 = 0, cmd_dummy3 = 0;
  logic [31:0] cmd_data3 = '0;
  logic cmd_ready3, rsp_valid3, rsp_is_dummy3, busy3, sck3, mosi3, cs_n3, miso3;
  logic [31:0] rsp_data3;
  logic [3:0] fifo_level3;
  int errors = 0, checks = 0, rsp_cnt = 0;
  logic [31:0] exp_mosi[$], miso_q[$];
  logic [32:0] exp_rsp[$], exp3[$];
  logic prev_cs = 1, prev_sck = 1;
  logic [31:0] mon_word, mw;
  logic [32:0] e_rsp;
  logic [31:0] e_mosi;
  int nb = 0, midx = 0;

  always #10 clk = ~clk;
  assign miso3 = mosi3;

  spi_cmd_sequencer #(.SCK_HALF(5), .FIFO_DEPTH(8)) u_dut (
    .clk_50M(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_dummy(cmd_dummy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_is_dummy(rsp_is_dummy),
    .busy(busy), .fifo_level(fifo_level), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );
  spi_cmd_sequencer #(.SCK_HALF(3), .FIFO_DEPTH(8)) u_dut3 (
    .clk_50M(clk), .rst_n(rst_n), .enable(enable3), .cmd_valid(cmd_valid3),
    .cmd_ready(cmd_ready3), .cmd_data(cmd_data3), .cmd_dummy(cmd_dummy3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_is_dummy(rsp_is_dummy3),
    .busy(busy3), .fifo_level(fifo_level3), .sck(sck3), .mosi(mosi3), .cs_n(cs_n3), .miso(miso3)
  );

  // slave model, mosi collector and response scoreboard for the H=5 instance
  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      nb = 0;
      mon_word = '0;
      mw = (miso_q.size() > 0) ? miso_q.pop_front() : 32'h0;
      midx = 0;
      miso = mw[0];
    end
    if (!cs_n && prev_sck && !sck && nb < 32) begin
      mon_word[nb] = mosi;
      nb++;
    end
    if (!cs_n && !prev_sck && sck && midx < 31) begin
      midx++;
      miso = mw[midx];
    end
    if (!prev_cs && cs_n && nb == 32) begin
      checks++;
      if (exp_mosi.size() == 0) begin
        errors++;
        $display("FAIL mosi_frame: got unexpected frame %h, want none", mon_word);
      end else begin
        e_mosi = exp_mosi.pop_front();
        if (mon_word !== e_mosi) begin
          errors++;
          $display("FAIL mosi_frame: got %h want %h", mon_word, e_mosi);
        end
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL rsp: got unexpected dummy=%b data=%h", rsp_is_dummy, rsp_data);
      end else begin
        e_rsp = exp_rsp.pop_front();
        if ({rsp_is_dummy, rsp_data} !== e_rsp) begin
          errors++;
          $display("FAIL rsp: got dummy=%b data=%h want dummy=%b data=%h",
                   rsp_is_dummy, rsp_data, e_rsp[32], e_rsp[31:0]);
        end
      end
    end
    prev_cs = cs_n;
    prev_sck = sck;
  end

  task automatic push(input logic [31:0] d, input logic dm, input logic [31:0] m0,
                      input logic [31:0] m1, input bit track);
    @(negedge clk);
    cmd_valid = 1;
    cmd_data = d;
    cmd_dummy = dm;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_dummy = 0;
    if (track) begin
      exp_mosi.push_back(d);
      exp_rsp.push_back({1'b0, m0});
      miso_q.push_back(m0);
      if (dm) begin
        exp_mosi.push_back('0);
        exp_rsp.push_back({1'b1, m1});
        miso_q.push_back(m1);
      end
    end
  endtask

  task automatic run_until_idle(output int lat, output int nbusy, output int ncs,
                                output int gap, output logic [3:0] lvl);
    int falls;
    logic pc;
    lat = 0; nbusy = 0; ncs = 0; gap = 0; falls = 0; pc = 1;
    while (busy !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    lvl = fifo_level;
    while (busy === 1'b1 && nbusy < 3000) begin
      if (pc && !cs_n) falls++;
      if (!cs_n) ncs++;
      else if (falls == 1) gap++;
      pc = cs_n;
      nbusy++;
      @(negedge clk);
    end
    checks++;
    if (lat >= 100 || nbusy >= 3000) begin
      errors++;
      $display("FAIL frame_timeout: got lat=%0d busy=%0d, want a frame that starts and ends", lat, nbusy);
    end
  endtask

  task automatic wait_bit(input int b, output bit ok);
    int n, t;
    logic ps;
    n = 0; t = 0;
    while (cs_n !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    ps = sck;
    while (n <= b && t < 5000) begin
      @(negedge clk);
      t++;
      if (ps && !sck) n++;
      ps = sck;
    end
    ok = n > b;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sck, cs_n, mosi, busy, rsp_valid, rsp_is_dummy, cmd_ready} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_pins: got sck,cs_n,mosi,busy,rsp_valid,rsp_is_dummy,cmd_ready=%b want 1100000",
               {sck, cs_n, mosi, busy, rsp_valid, rsp_is_dummy, cmd_ready});
    end
    checks++;
    if (rsp_data !== 32'h0 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: got rsp_data=%h level=%0d want 0 and 0", rsp_data, fifo_level);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single;
    int lat, nbz, ncs, gap, r0;
    logic [3:0] lvl;
    enable = 1;
    r0 = rsp_cnt;
    push(pack_frame(CMD_AFE_RST_OFF, 10'd4, 16'h0), 0, 32'h1357_9BDF, 32'h0, 1);
    run_until_idle(lat, nbz, ncs, gap, lvl);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL start_latency: got %0d want 2", lat); end
    checks++;
    if (nbz != 335) begin errors++; $display("FAIL single_busy: got %0d want 335", nbz); end
    checks++;
    if (ncs != 325) begin errors++; $display("FAIL single_cs_low: got %0d want 325", ncs); end
    checks++;
    if (rsp_cnt - r0 != 1) begin errors++; $display("FAIL single_rsp_count: got %0d want 1", rsp_cnt - r0); end
    checks++;
    if (exp_rsp.size() + exp_mosi.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got %0d outstanding want 0", exp_rsp.size() + exp_mosi.size());
    end
  endtask

  task automatic test_dummy;
    int lat, nbz, ncs, gap, r0;
    logic [3:0] lvl;
    r0 = rsp_cnt;
    push(pack_frame(CMD_RD_ADC, {8'd2, 2'd3}, 16'h0), 1, 32'h0, 32'hA5A5_1234, 1);
    run_until_idle(lat, nbz, ncs, gap, lvl);
    checks++;
    if (nbz != 665) begin errors++; $display("FAIL dummy_busy: got %0d want 665", nbz); end
    checks++;
    if (ncs != 650) begin errors++; $display("FAIL dummy_cs_low: got %0d want 650", ncs); end
    checks++;
    if (gap != 5) begin errors++; $display("FAIL dummy_gap: got %0d want 5", gap); end
    checks++;
    if (rsp_cnt - r0 != 2) begin errors++; $display("FAIL dummy_rsp_count: got %0d want 2", rsp_cnt - r0); end
  endtask

  task automatic test_fifo_full;
    int lat, nbz, ncs, gap, r0;
    logic [3:0] lvl;
    enable = 0;
    r0 = rsp_cnt;
    for (int i = 0; i < 9; i++)
      push(pack_frame(CMD_WR_REC, 10'(i), 16'(i * 16'h1111)), 0, $urandom, 32'h0, i < 8);
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd8 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: got level=%0d ready=%b busy=%b want 8 0 0", fifo_level, cmd_ready, busy);
    end
    enable = 1;
    for (int k = 0; k < 8; k++) begin
      run_until_idle(lat, nbz, ncs, gap, lvl);
      checks++;
      if (lvl !== 4'(7 - k)) begin
        errors++;
        $display("FAIL fifo_pop_level: frame %0d got %0d want %0d", k, lvl, 7 - k);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (fifo_level !== 4'd0 || busy !== 1'b0 || rsp_cnt - r0 != 8) begin
      errors++;
      $display("FAIL fifo_drain: got level=%0d busy=%b rsps=%0d want 0 0 8", fifo_level, busy, rsp_cnt - r0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int r0;
    enable = 1;
    r0 = rsp_cnt;
    push(pack_frame(CMD_WR_REC, 10'h3FF, 16'hBEEF), 1, 32'h0, 32'h0, 0);
    push(pack_frame(CMD_RD_ELEC, 10'h1, 16'h1), 0, 32'h0, 32'h0, 0);
    wait_bit(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_reach: got timeout want bit 10"); end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({sck, cs_n, mosi, busy} !== 4'b1100 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_pins: got sck,cs_n,mosi,busy=%b level=%0d want 1100 0",
               {sck, cs_n, mosi, busy}, fifo_level);
    end
    rst_n = 1;
    repeat (400) @(negedge clk);
    checks++;
    if (rsp_cnt != r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got rsps=%0d busy=%b want 0 0", rsp_cnt - r0, busy);
    end
    miso_q.delete();
  endtask

  task automatic test_enable_mid;
    bit ok;
    int lat, nbz, ncs, gap, r0;
    logic [3:0] lvl;
    r0 = rsp_cnt;
    push(pack_frame(CMD_RD_ADC, 10'h2A, 16'h0), 1, 32'h0F0F_00FF, 32'h8000_0001, 1);
    for (int i = 0; i < 3; i++)
      push(pack_frame(CMD_RD_ELEC, 10'(i + 100), 16'hC0DE), 0, $urandom, 32'h0, 1);
    wait_bit(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL enable_mid_reach: got timeout want bit 5"); end
    enable = 0;
    run_until_idle(lat, nbz, ncs, gap, lvl);
    repeat (20) @(negedge clk);
    checks++;
    if (rsp_cnt - r0 != 2 || busy !== 1'b0 || fifo_level !== 4'd3) begin
      errors++;
      $display("FAIL enable_mid_hold: got rsps=%0d busy=%b level=%0d want 2 0 3", rsp_cnt - r0, busy, fifo_level);
    end
    enable = 1;
    for (int i = 0; i < 3; i++) run_until_idle(lat, nbz, ncs, gap, lvl);
    checks++;
    if (rsp_cnt - r0 != 5 || exp_rsp.size() + exp_mosi.size() != 0) begin
      errors++;
      $display("FAIL enable_mid_resume: got rsps=%0d outstanding=%0d want 5 0",
               rsp_cnt - r0, exp_rsp.size() + exp_mosi.size());
    end
  endtask

  task automatic test_sck3;
    int t, nbz;
    logic [32:0] e;
    enable3 = 1;
    @(negedge clk);
    cmd_valid3 = 1;
    cmd_data3 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    cmd_valid3 = 0;
    exp3.push_back({1'b0, 32'hDEAD_BEEF});
    t = 0;
    while (busy3 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    nbz = 0;
    while (busy3 === 1'b1 && nbz < 1000) begin
      if (rsp_valid3 === 1'b1) begin
        checks++;
        if (exp3.size() == 0) begin
          errors++;
          $display("FAIL sck3_rsp: got unexpected data=%h", rsp_data3);
        end else begin
          e = exp3.pop_front();
          if ({rsp_is_dummy3, rsp_data3} !== e) begin
            errors++;
            $display("FAIL sck3_rsp: got dummy=%b data=%h want dummy=%b data=%h",
                     rsp_is_dummy3, rsp_data3, e[32], e[31:0]);
          end
        end
      end
      nbz++;
      @(negedge clk);
    end
    checks++;
    if (nbz != 201) begin errors++; $display("FAIL sck3_busy: got %0d want 201", nbz); end
    checks++;
    if (exp3.size() != 0) begin errors++; $display("FAIL sck3_drain: got %0d outstanding want 0", exp3.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_dummy;
    test_fifo_full;
    test_reset_mid;
    test_enable_mid;
    test_sck3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
Synthesizable SPI master and command scheduler for the probe's 32-bit SPI command link. Host logic pushes frames into a small command FIFO. The block serializes each frame LSB-first with the link's fixed sck/cs_n timing and captures miso into a response word. For read-type commands it can append an all-zero dummy frame, which clocks out the previous command's read data. It sits between the FPGA command/host logic and the chip's sck/mosi/miso/cs_n pads.

Parameters:
LEN_SPI, 32, frame length in bits.
SPI_CODE_LEN, 6, command code field width, frame bits [31:26].
SPI_ADDR_LEN, 10, address field width, frame bits [25:16].
SPI_DATA_LEN, 16, data field width, frame bits [15:0].
SCK_HALF, 5, sck half period in clk_50M cycles (5 gives 5 MHz sck); legal range 3..255.
FIFO_DEPTH, 8, command FIFO entries; must be a power of 2.

Ports:
clk_50M  input  1  system clock, 50 MHz
rst_n  input  1  synchronous, active-low reset
enable  input  1  when low, the current frame finishes and no new frame starts
cmd_valid  input  1  push request
cmd_ready  output  1  equals !fifo_full; 0 while rst_n is low
cmd_data  input  LEN_SPI  frame {code, addr, data}
cmd_dummy  input  1  append one all-zero frame after this frame
rsp_valid  output  1  one-cycle pulse, response word available
rsp_data  output  LEN_SPI  miso bits captured during the completed frame
rsp_is_dummy  output  1  rsp_data belongs to an auto-inserted dummy frame
busy  output  1  1 from frame start until return to IDLE
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued commands
sck  output  1  SPI clock, idles high
mosi  output  1  SPI data out
cs_n  output  1  chip select, active low
miso  input  1  SPI data in (asynchronous; two-flop synchronizer inside)

Behaviour:
- Reset (rst_n low at a clk edge) applies mid-frame too: sck=1, cs_n=1, mosi=0, rsp_valid=0, rsp_data=0, rsp_is_dummy=0, busy=0, FIFO flushed (fifo_level=0), state=IDLE. No partial response is emitted.
- Push: a command is accepted when cmd_valid && cmd_ready. Push and pop in the same cycle are allowed; fifo_level is unchanged by such a cycle. A push while full is ignored.
- FSM states and H=SCK_HALF counter phases:
- IDLE: if enable and FIFO is not empty, pop the FIFO into the shift register, latch the dummy flag, and go to PRE. busy goes to 1.
- PRE: cs_n=1, sck=1 for H cycles.
- SETUP: cs_n=0, sck=1, mosi=bit0 for H cycles.
- LOW: sck=0 for H cycles. On the last LOW cycle the synchronized miso is written into capture bit i.
- HIGH: sck=1 for H cycles. mosi updates to bit i+1 on entry. After bit 31's LOW phase, go to TAIL instead of HIGH.
- TAIL: sck=1, mosi=0, cs_n=0 for H cycles.
- POST: cs_n=1 for H cycles. On entry, rsp_valid pulses with rsp_data = captured word.
- After POST: if the latched dummy flag is set, start a dummy frame (shift register = 0, rsp_is_dummy=1 on its response) going directly to SETUP, because POST already provided the cs_n-high gap. Otherwise go to IDLE.
- Frame length: PRE H + SETUP H + 31x2H + last LOW H + TAIL H + POST H = 67H cycles (335 clocks at H=5). A dummy frame is 66H.
- Bit order: bit i of cmd_data is driven on the i-th sck high phase. miso bit i is captured during the i-th sck low phase.
- enable deasserted mid-frame: the frame and any pending dummy complete; the FSM then holds in IDLE.
- Simultaneous push into an empty FIFO while in IDLE: the frame starts on the next cycle (one cycle of FIFO latency).
- rsp_valid has no backpressure; the consumer must accept it in the pulse cycle.

Decomposition:
- Package spi_seq_pkg holds: LEN_SPI and field widths; field offsets; the FSM state enum (IDLE, PRE, SETUP, LOW, HIGH, TAIL, POST); command code constants (CMD_DUMMY=0, CMD_AFE_RST_OFF=8, CMD_WR_REC=4, CMD_RD_ADC=19, CMD_RD_ELEC=11); and a helper that packs code/addr/data into a frame.
- One sub-module, spi_cmd_fifo: synchronous FIFO, width LEN_SPI+1, depth FIFO_DEPTH, with level output.

Test Plan:
- Push {6'd8,10'd4,16'h0}, no dummy -> mosi over 32 sck highs is 0x0 for bits 0..15, bit18=1, bit29=1, all others 0. cs_n low for 65H=325 clocks. One rsp_valid. busy high for 335 clocks.
- Push {6'd19,{8'd2,2'd3},16'h0} with cmd_dummy=1; bench miso model drives 32'hA5A5_1234 LSB-first, changing on sck rise, during the dummy frame only -> second rsp_valid has rsp_data=32'hA5A51234 and rsp_is_dummy=1. The two cs_n frames are separated by exactly H=5 clocks of cs_n high.
- With enable=0, push 9 commands -> 8 accepted, fifo_level=8, cmd_ready=0, 9th ignored. Set enable=1 -> 8 frames are sent in order and fifo_level decrements at each pop.
- Assert rst_n low for 1 cycle at bit 10 of a frame -> on the next clock sck=1, cs_n=1, mosi=0, fifo_level=0. No rsp_valid is emitted.
- Deassert enable during bit 5 of a frame that has a dummy pending -> the frame and its dummy complete with 2 rsp_valid pulses, then the FSM stays in IDLE with 3 commands still queued.
- Set SCK_HALF=3 -> frame length is 201 clocks and the loopback word 32'hDEADBEEF is captured correctly.
